// File: rtl/jtag_master_seq.sv
// jtag_master_seq: system-clock JTAG master that runs an optional IR scan followed by an optional DR scan.
// Latency: each TCK step takes 2*CLK_DIV CLK cycles. IR scan is IR_LEN+6 steps, DR scan is N+5 steps,
//          and the post-reset TLR walk is 6 steps. A request with no scans reports done 2 CLK after start.
// Backpressure: start is taken only while busy=0. Starts that arrive while busy are dropped, not queued.
// Ports: CLK/RST_N are the clock and async active-low reset. start/do_ir/do_dr/ir_value/dr_value/dr_len
//        form the request and are latched at start. busy/done/dr_captured report status.
//        TCK/TMS/TDI/TDO connect to the TAP.
module jtag_master_seq #(
    parameter int IR_LEN  = 4,
    parameter int DR_MAX  = 16,
    parameter int CLK_DIV = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        start,
    input  logic                        do_ir,
    input  logic                        do_dr,
    input  logic [IR_LEN-1:0]           ir_value,
    input  logic [DR_MAX-1:0]           dr_value,
    input  logic [$clog2(DR_MAX+1)-1:0] dr_len,
    output logic                        busy,
    output logic                        done,
    output logic [DR_MAX-1:0]           dr_captured,
    output logic                        TCK,
    output logic                        TMS,
    output logic                        TDI,
    input  logic                        TDO
);
    localparam int LW   = $clog2(DR_MAX + 1);
    localparam int SMX1 = (DR_MAX > IR_LEN) ? DR_MAX : IR_LEN;
    localparam int SMAX = (SMX1 > 6) ? SMX1 : 6;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        TLR_SEQ, IDLE, IR_HEAD, IR_SHIFT, IR_TAIL, DR_HEAD, DR_SHIFT, DR_TAIL, FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     step, step_nxt;
    logic [DW-1:0]     div_cnt, div_nxt;
    logic [IR_LEN-1:0] ir_sh, ir_sh_nxt;
    logic [DR_MAX-1:0] dr_sh, dr_sh_nxt;
    logic [LW-1:0]     dr_cnt, dr_cnt_nxt;
    logic              dr_lat, dr_lat_nxt;
    logic [DR_MAX-1:0] cap_sh, cap_sh_nxt;
    logic [DR_MAX-1:0] cap_mask, cap_mask_nxt;
    logic [DR_MAX-1:0] cap_out_nxt;
    logic              tck_nxt, tms_nxt, tdi_nxt, busy_nxt, done_nxt;
    logic              running, div_last, rise, step_end;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= TLR_SEQ;
            step        <= '0;
            div_cnt     <= '0;
            ir_sh       <= '0;
            dr_sh       <= '0;
            dr_cnt      <= '0;
            dr_lat      <= 1'b0;
            cap_sh      <= '0;
            cap_mask    <= '0;
            dr_captured <= '0;
            TCK         <= 1'b0;
            TMS         <= 1'b1;
            TDI         <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            step        <= step_nxt;
            div_cnt     <= div_nxt;
            ir_sh       <= ir_sh_nxt;
            dr_sh       <= dr_sh_nxt;
            dr_cnt      <= dr_cnt_nxt;
            dr_lat      <= dr_lat_nxt;
            cap_sh      <= cap_sh_nxt;
            cap_mask    <= cap_mask_nxt;
            dr_captured <= cap_out_nxt;
            TCK         <= tck_nxt;
            TMS         <= tms_nxt;
            TDI         <= tdi_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        div_nxt      = '0;
        ir_sh_nxt    = ir_sh;
        dr_sh_nxt    = dr_sh;
        dr_cnt_nxt   = dr_cnt;
        dr_lat_nxt   = dr_lat;
        cap_sh_nxt   = cap_sh;
        cap_mask_nxt = cap_mask;
        cap_out_nxt  = dr_captured;
        tck_nxt      = 1'b0;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        tms_nxt      = 1'b0;
        tdi_nxt      = 1'b0;

        // TCK runs only while a TAP walk is active. Each half-period is CLK_DIV cycles.
        running  = (state != IDLE) && (state != FINISH);
        div_last = (div_cnt == DW'(CLK_DIV - 1));
        rise     = running && !TCK && div_last;
        step_end = running && TCK && div_last;
        if (running) begin
            div_nxt = div_last ? '0 : div_cnt + DW'(1);
            tck_nxt = div_last ? ~TCK : TCK;
        end

        // Capture TDO in the same CLK edge that raises TCK. The one-hot mask right-aligns the bits.
        if (rise && state == DR_SHIFT)
            cap_sh_nxt = cap_sh | (TDO ? cap_mask : '0);

        case (state)
            TLR_SEQ: if (step_end) begin
                if (step == SW'(5)) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                    busy_nxt  = 1'b0;
                end else step_nxt = step + SW'(1);
            end
            IDLE: if (start) begin
                ir_sh_nxt    = ir_value;
                dr_sh_nxt    = dr_value;
                dr_cnt_nxt   = (dr_len == '0 || dr_len > LW'(DR_MAX)) ? LW'(DR_MAX) : dr_len;
                dr_lat_nxt   = do_dr;
                cap_sh_nxt   = '0;
                cap_mask_nxt = DR_MAX'(1);
                busy_nxt     = 1'b1;
                step_nxt     = '0;
                state_nxt    = do_ir ? IR_HEAD : (do_dr ? DR_HEAD : FINISH);
            end
            IR_HEAD: if (step_end) begin
                if (step == SW'(3)) begin
                    state_nxt = IR_SHIFT;
                    step_nxt  = '0;
                end else step_nxt = step + SW'(1);
            end
            IR_SHIFT: if (step_end) begin
                ir_sh_nxt = ir_sh >> 1;
                if (step == SW'(IR_LEN - 1)) begin
                    state_nxt = IR_TAIL;
                    step_nxt  = '0;
                end else step_nxt = step + SW'(1);
            end
            IR_TAIL: if (step_end) begin
                if (step == SW'(1)) begin
                    state_nxt = dr_lat ? DR_HEAD : FINISH;
                    step_nxt  = '0;
                end else step_nxt = step + SW'(1);
            end
            DR_HEAD: if (step_end) begin
                if (step == SW'(2)) begin
                    state_nxt = DR_SHIFT;
                    step_nxt  = '0;
                end else step_nxt = step + SW'(1);
            end
            DR_SHIFT: if (step_end) begin
                dr_sh_nxt    = dr_sh >> 1;
                cap_mask_nxt = cap_mask << 1;
                if (step == SW'(dr_cnt) - SW'(1)) begin
                    // Unshifted positions of cap_sh stay 0, so the upper bits are zeroed here.
                    cap_out_nxt = cap_sh;
                    state_nxt   = DR_TAIL;
                    step_nxt    = '0;
                end else step_nxt = step + SW'(1);
            end
            DR_TAIL: if (step_end) begin
                if (step == SW'(1)) begin
                    state_nxt = FINISH;
                    step_nxt  = '0;
                end else step_nxt = step + SW'(1);
            end
            FINISH: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = TLR_SEQ;
        endcase

        // TMS/TDI are decoded from the next step. They move only when a step ends (TCK falling)
        // or when TCK is idle.
        case (state_nxt)
            TLR_SEQ:  tms_nxt = (step_nxt < SW'(5));
            IR_HEAD:  tms_nxt = (step_nxt < SW'(2));
            IR_SHIFT: tms_nxt = (step_nxt == SW'(IR_LEN - 1));
            IR_TAIL:  tms_nxt = (step_nxt == '0);
            DR_HEAD:  tms_nxt = (step_nxt == '0);
            DR_SHIFT: tms_nxt = (step_nxt == SW'(dr_cnt_nxt) - SW'(1));
            DR_TAIL:  tms_nxt = (step_nxt == '0);
            default:  tms_nxt = 1'b0;
        endcase
        if (state_nxt == IR_SHIFT)      tdi_nxt = ir_sh_nxt[0];
        else if (state_nxt == DR_SHIFT) tdi_nxt = dr_sh_nxt[0];
    end
endmodule

// File: tb/tb_jtag_master_seq.sv
module tb_jtag_master_seq;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0, do_ir = 1'b0, do_dr = 1'b0;
    logic [3:0]  ir_value = '0;
    logic [15:0] dr_value = '0;
    logic [4:0]  dr_len = '0;
    logic        busy, done, TCK, TMS, TDI, TDO;
    logic [15:0] dr_captured;

    jtag_master_seq #(.IR_LEN(4), .DR_MAX(16), .CLK_DIV(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .do_ir(do_ir), .do_dr(do_dr),
        .ir_value(ir_value), .dr_value(dr_value), .dr_len(dr_len),
        .busy(busy), .done(done), .dr_captured(dr_captured),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 CLK = ~CLK;

    // Board TAP model: 4-bit IR, 9-bit BSR (SAMPLE/PRELOAD), 32-bit IDCODE, 1-bit BYPASS.
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;
    localparam logic [3:0]  INS_SAMPLE = 4'b0001;
    localparam logic [3:0]  INS_IDCODE = 4'b0010;
    localparam logic [31:0] IDCODE     = 32'h1234_5093;

    tap_t        tap = SH_DR;
    logic [3:0]  ir_reg = INS_IDCODE, ir_sh = '0;
    logic [8:0]  bsr = '0, bsr_pre_val = '0;
    logic        bsr_pre = 1'b0, byp = 1'b0, tck_prev = 1'b0;
    logic [31:0] id_sh = '0;
    logic [7:0]  tms_hist = '0;
    int          edge_cnt = 0, done_cnt = 0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:    return m ? TLR    : RTI;
            RTI:    return m ? SEL_DR : RTI;
            SEL_DR: return m ? SEL_IR : CAP_DR;
            CAP_DR: return m ? EX1_DR : SH_DR;
            SH_DR:  return m ? EX1_DR : SH_DR;
            EX1_DR: return m ? UPD_DR : PA_DR;
            PA_DR:  return m ? EX2_DR : PA_DR;
            EX2_DR: return m ? UPD_DR : SH_DR;
            UPD_DR: return m ? SEL_DR : RTI;
            SEL_IR: return m ? TLR    : CAP_IR;
            CAP_IR: return m ? EX1_IR : SH_IR;
            SH_IR:  return m ? EX1_IR : SH_IR;
            EX1_IR: return m ? UPD_IR : PA_IR;
            PA_IR:  return m ? EX2_IR : PA_IR;
            EX2_IR: return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge CLK) begin
        tck_prev <= TCK;
        if (bsr_pre) bsr <= bsr_pre_val;
        if (done) done_cnt <= done_cnt + 1;
        if (TCK && !tck_prev) begin
            edge_cnt <= edge_cnt + 1;
            tms_hist <= {tms_hist[6:0], TMS};
            case (tap)
                TLR:    ir_reg <= INS_IDCODE;
                CAP_IR: ir_sh <= 4'b0001;
                SH_IR:  ir_sh <= {TDI, ir_sh[3:1]};
                UPD_IR: ir_reg <= ir_sh;
                CAP_DR: begin byp <= 1'b0; id_sh <= IDCODE; end
                SH_DR: begin
                    if (ir_reg == INS_SAMPLE)      bsr <= {TDI, bsr[8:1]};
                    else if (ir_reg == INS_IDCODE) id_sh <= {TDI, id_sh[31:1]};
                    else                           byp <= TDI;
                end
                default: ;
            endcase
            tap <= tap_next(tap, TMS);
        end
    end

    assign TDO = (tap == SH_IR) ? ir_sh[0] :
                 (tap == SH_DR) ? ((ir_reg == INS_SAMPLE) ? bsr[0] :
                                   (ir_reg == INS_IDCODE) ? id_sh[0] : byp) : 1'b0;

    int errors = 0, checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!done && n < budget) begin @(negedge CLK); n++; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy && n < budget) begin @(negedge CLK); n++; end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still high after %0d cycles", nm, budget);
        end
    endtask

    task automatic pulse_start(input logic i_ir, input logic i_dr, input logic [3:0] iv,
                               input logic [15:0] dv, input logic [4:0] dl);
        do_ir = i_ir; do_dr = i_dr; ir_value = iv; dr_value = dv; dr_len = dl;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    typedef struct {
        logic        do_ir, do_dr;
        logic [3:0]  ir;
        logic [15:0] dr;
        logic [4:0]  len;
        logic        pre;
        logic [8:0]  pre_val;
        int          edges;
        logic [15:0] cap;
        logic [8:0]  bsr;
        logic [3:0]  irr;
    } vec_t;
    vec_t vecs[7];

    int e0, d0;

    initial begin
        //           ir    dr    ir     dr        len  pre   pre_val  edges cap       bsr     irr
        vecs[0] = '{1'b1, 1'b1, 4'h1, 16'h00E9, 5'd9,  1'b0, 9'h000, 24, 16'h0000, 9'h0E9, 4'h1};
        vecs[1] = '{1'b0, 1'b1, 4'h0, 16'h0000, 5'd9,  1'b1, 9'h155, 14, 16'h0155, 9'h000, 4'h1};
        vecs[2] = '{1'b0, 1'b1, 4'h0, 16'hA5C3, 5'd0,  1'b0, 9'h000, 21, 16'h8600, 9'h14B, 4'h1};
        vecs[3] = '{1'b0, 1'b1, 4'h0, 16'hFFFF, 5'd20, 1'b0, 9'h000, 21, 16'hFF4B, 9'h1FF, 4'h1};
        vecs[4] = '{1'b1, 1'b0, 4'hF, 16'h1234, 5'd5,  1'b0, 9'h000, 10, 16'hFF4B, 9'h1FF, 4'hF};
        vecs[5] = '{1'b0, 1'b1, 4'h0, 16'h000B, 5'd4,  1'b0, 9'h000,  9, 16'h0006, 9'h1FF, 4'hF};
        vecs[6] = '{1'b1, 1'b1, 4'h1, 16'h0005, 5'd3,  1'b0, 9'h000, 18, 16'h0007, 9'h17F, 4'h1};

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_tck", 32'(TCK), 32'd0);
        check("rst_tms", 32'(TMS), 32'd1);
        check("rst_tdi", 32'(TDI), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cap", 32'(dr_captured), 32'd0);

        // Post-reset TLR walk
        e0 = edge_cnt;
        RST_N = 1'b1;
        wait_idle(400, "tlr_idle");
        repeat (2) @(negedge CLK);
        check("tlr_edges", 32'(edge_cnt - e0), 32'd6);
        check("tlr_tms", 32'(tms_hist[5:0]), 32'b111110);
        check("tlr_no_done", 32'(done_cnt), 32'd0);
        check("tlr_tap", 32'(tap), 32'(RTI));
        check("tlr_ir", 32'(ir_reg), 32'(INS_IDCODE));

        // Table-driven scans
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (vecs[i].pre) begin
                bsr_pre_val = vecs[i].pre_val;
                bsr_pre = 1'b1;
                @(negedge CLK);
                bsr_pre = 1'b0;
            end
            e0 = edge_cnt;
            d0 = done_cnt;
            pulse_start(vecs[i].do_ir, vecs[i].do_dr, vecs[i].ir, vecs[i].dr, vecs[i].len);
            wait_done(400, $sformatf("v%0d_done", i));
            repeat (3) @(negedge CLK);
            check($sformatf("v%0d_edges", i), 32'(edge_cnt - e0), 32'(vecs[i].edges));
            check($sformatf("v%0d_cap", i), 32'(dr_captured), 32'(vecs[i].cap));
            check($sformatf("v%0d_bsr", i), 32'(bsr), 32'(vecs[i].bsr));
            check($sformatf("v%0d_ir", i), 32'(ir_reg), 32'(vecs[i].irr));
            check($sformatf("v%0d_tap", i), 32'(tap), 32'(RTI));
            check($sformatf("v%0d_ndone", i), 32'(done_cnt - d0), 32'd1);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // No-scan request: busy for one CLK, done two CLK after start, no TCK edges
        e0 = edge_cnt;
        pulse_start(1'b0, 1'b0, 4'h0, 16'h0, 5'd0);
        check("nop_busy1", 32'(busy), 32'd1);
        check("nop_done1", 32'(done), 32'd0);
        @(negedge CLK);
        check("nop_done2", 32'(done), 32'd1);
        check("nop_busy2", 32'(busy), 32'd0);
        @(negedge CLK);
        check("nop_done3", 32'(done), 32'd0);
        check("nop_edges", 32'(edge_cnt - e0), 32'd0);

        // start during busy is dropped, and input changes mid-scan are ignored
        @(negedge CLK);
        e0 = edge_cnt;
        d0 = done_cnt;
        pulse_start(1'b0, 1'b1, 4'h0, 16'h0000, 5'd9);
        repeat (4) @(negedge CLK);
        for (int k = 0; k < 4; k++) pulse_start(1'b1, 1'b1, 4'hF, 16'hFFFF, 5'd3);
        wait_done(400, "busy_done");
        repeat (100) @(negedge CLK);
        check("busy_ndone", 32'(done_cnt - d0), 32'd1);
        check("busy_edges", 32'(edge_cnt - e0), 32'd14);
        check("busy_cap", 32'(dr_captured), 32'h017F);
        check("busy_bsr", 32'(bsr), 32'h000);
        check("busy_ir", 32'(ir_reg), 32'(INS_SAMPLE));

        // Reset in the middle of IR_SHIFT
        pulse_start(1'b1, 1'b1, 4'hF, 16'h0001, 5'd9);
        begin
            int n = 0;
            while (tap != SH_IR && n < 400) begin @(negedge CLK); n++; end
            check("mid_reach_shir", 32'(tap), 32'(SH_IR));
        end
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("mid_tck", 32'(TCK), 32'd0);
        check("mid_tms", 32'(TMS), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_cap", 32'(dr_captured), 32'd0);
        repeat (3) @(negedge CLK);
        e0 = edge_cnt;
        d0 = done_cnt;
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        pulse_start(1'b0, 1'b0, 4'h0, 16'h0, 5'd0);
        wait_idle(400, "mid_idle");
        repeat (3) @(negedge CLK);
        check("mid_tlr_edges", 32'(edge_cnt - e0), 32'd6);
        check("mid_tlr_tms", 32'(tms_hist[5:0]), 32'b111110);
        check("mid_tap", 32'(tap), 32'(RTI));
        check("mid_ir", 32'(ir_reg), 32'(INS_IDCODE));
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);

        // Scans after recovery: read the IDCODE low half, then SAMPLE/PRELOAD
        @(negedge CLK);
        e0 = edge_cnt;
        pulse_start(1'b0, 1'b1, 4'h0, 16'h0000, 5'd16);
        wait_done(400, "post_id_done");
        repeat (3) @(negedge CLK);
        check("post_id_cap", 32'(dr_captured), 32'h5093);
        check("post_id_edges", 32'(edge_cnt - e0), 32'd21);
        e0 = edge_cnt;
        pulse_start(1'b1, 1'b1, 4'h1, 16'h00E9, 5'd9);
        wait_done(400, "post_bsr_done");
        repeat (3) @(negedge CLK);
        check("post_bsr", 32'(bsr), 32'h0E9);
        check("post_bsr_edges", 32'(edge_cnt - e0), 32'd24);
        check("post_tdi_idle", 32'(TDI), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
